iq_magnitude_sqrt: RTL and testbench

Sequential magnitude calculator for one complex baseband sample. It accepts signed 16-bit I and Q values (Q0.15), forms I²+Q², and returns the floor of the square root as an unsigned 16-bit value on the same scale. The square root uses a bit-serial digit-by-digit method. The block sits after the IQ datapath and feeds envelope and level-detection logic through a start/done handshake.

---
 rtl/iq_magnitude_sqrt.sv | 99 +++++++++
 tb/tb_iq_magnitude_sqrt.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/iq_magnitude_sqrt.sv
// Magnitude of one complex sample: floor(sqrt(I^2 + Q^2)).
// The root is found by a restoring digit-by-digit iteration, one bit per clock.
module iq_magnitude_sqrt (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] I_in,
    input  logic [15:0] Q_in,
    output logic [15:0] magnitude,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE,
        SQUARE,
        SQRT
    } state_t;

    state_t             state_q;
    logic signed [15:0] i_q;
    logic signed [15:0] q_q;
    logic        [31:0] rad_q;
    logic        [15:0] root_q;
    logic        [19:0] rem_q;
    logic        [3:0]  cnt_q;
    logic               sat_q;
    logic        [15:0] mag_q;
    logic               done_q;

    logic signed [31:0] sq_i;
    logic signed [31:0] sq_q;
    logic        [32:0] sum_sq;
    logic        [19:0] rem_sh;
    logic        [19:0] trial;
    logic               ge;
    logic        [19:0] rem_d;
    logic        [15:0] root_d;

    assign sq_i   = i_q * i_q;
    assign sq_q   = q_q * q_q;
    assign sum_sq = {1'b0, sq_i} + {1'b0, sq_q};

    assign rem_sh = (rem_q << 2) | {18'd0, rad_q[31:30]};
    assign trial  = {2'b00, root_q, 2'b01};
    assign ge     = (rem_sh >= trial);
    assign rem_d  = ge ? (rem_sh - trial) : rem_sh;
    assign root_d = {root_q[14:0], ge};

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            i_q     <= '0;
            q_q     <= '0;
            rad_q   <= '0;
            root_q  <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
            mag_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        i_q     <= I_in;
                        q_q     <= Q_in;
                        state_q <= SQUARE;
                    end
                end
                SQUARE: begin
                    rad_q   <= sum_sq[31:0];
                    sat_q   <= sum_sq[32];
                    root_q  <= '0;
                    rem_q   <= '0;
                    cnt_q   <= '0;
                    state_q <= SQRT;
                end
                SQRT: begin
                    rad_q  <= rad_q << 2;
                    rem_q  <= rem_d;
                    root_q <= root_d;
                    cnt_q  <= cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        // An overflowed radicand cannot be rooted in 16 bits.
                        mag_q   <= sat_q ? 16'hFFFF : root_d;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign magnitude = mag_q;
    assign done      = done_q;

endmodule

// File: tb/tb_iq_magnitude_sqrt.sv
// Directed and random checks for iq_magnitude_sqrt.
// Inputs change on the falling edge; outputs are sampled there too.
module tb_iq_magnitude_sqrt;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] I_in;
    logic [15:0] Q_in;
    logic [15:0] magnitude;
    logic        done;

    int tests;
    int fails;

    iq_magnitude_sqrt dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .I_in     (I_in),
        .Q_in     (Q_in),
        .magnitude(magnitude),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] isqrt(input longint n);
        logic [15:0] r;
        logic [15:0] t;
        r = '0;
        for (int b = 15; b >= 0; b--) begin
            t = r | (16'd1 << b);
            if (longint'(t) * longint'(t) <= n) r = t;
        end
        return r;
    endfunction

    // One operation; glitch/rst_at give the cycle of an extra start or a
    // reset pulse (0 = none). Watches 30 cycles and returns what it saw.
    task automatic run(input logic [15:0] i, input logic [15:0] q,
                       input int glitch, input int rst_at,
                       output int npulse, output int first,
                       output logic [15:0] mag);
        int c;
        I_in   = i;
        Q_in   = q;
        start  = 1'b1;
        npulse = 0;
        first  = -1;
        mag    = 'x;
        @(negedge clk);
        start = 1'b0;
        I_in  = 16'h1234;
        Q_in  = 16'h5678;
        for (c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (done) begin
                npulse++;
                if (first < 0) begin
                    first = c;
                    mag   = magnitude;
                end
            end
            start = (c == glitch);
            if (c == glitch) begin
                I_in = 16'h0007;
                Q_in = 16'h0009;
            end
            if (c == rst_at) rst = 1'b0;
            if (c == rst_at + 2) rst = 1'b1;
        end
        start = 1'b0;
    endtask

    task automatic op(input string tag, input logic [15:0] i,
                      input logic [15:0] q, input logic [15:0] exp);
        int np;
        int fc;
        logic [15:0] m;
        run(i, q, 0, 0, np, fc, m);
        check({tag, " mag"}, 32'(m), 32'(exp));
        check({tag, " lat"}, 32'(fc), 32'd17);
        check({tag, " pulses"}, 32'(np), 32'd1);
    endtask

    initial begin
        int np;
        int fc;
        logic [15:0] m;
        logic [15:0] ri;
        logic [15:0] rq;
        longint n;
        tests = 0;
        fails = 0;
        rst   = 1'b0;
        start = 1'b0;
        I_in  = '0;
        Q_in  = '0;
        @(negedge clk);
        @(negedge clk);
        check("reset mag", 32'(magnitude), 32'd0);
        check("reset done", 32'(done), 32'd0);
        rst = 1'b1;
        np  = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done) np++;
        end
        check("idle no done", 32'(np), 32'd0);

        op("3,4", 16'd3, 16'd4, 16'd5);
        op("-3,-4", -16'sd3, -16'sd4, 16'd5);
        op("fs 32767", 16'd32767, 16'd32767, 16'd46339);
        op("24576", 16'd24576, 16'd24576, 16'd34755);
        op("32000", 16'd32000, 16'd32000, 16'd45254);
        op("1e4,2e4", 16'd10000, 16'd20000, 16'd22360);
        op("-32768", 16'h8000, 16'h8000, 16'd46340);
        op("zero", 16'd0, 16'd0, 16'd0);
        op("255,0", 16'd255, 16'd0, 16'd255);
        op("-32768,0", 16'h8000, 16'd0, 16'd32768);

        run(16'd3, 16'd4, 5, 0, np, fc, m);
        check("glitch mag", 32'(m), 32'd5);
        check("glitch lat", 32'(fc), 32'd17);
        check("glitch pulses", 32'(np), 32'd1);

        run(16'd1000, 16'd1000, 0, 8, np, fc, m);
        check("abort pulses", 32'(np), 32'd0);
        check("abort mag", 32'(magnitude), 32'd0);

        op("after abort", 16'd6, 16'd8, 16'd10);

        for (int k = 0; k < 1000; k++) begin
            ri = 16'($urandom);
            rq = 16'($urandom);
            n  = longint'($signed(ri)) * longint'($signed(ri))
               + longint'($signed(rq)) * longint'($signed(rq));
            run(ri, rq, 0, 0, np, fc, m);
            if (m !== isqrt(n) || fc != 17 || np != 1)
                $display("random case I=%0d Q=%0d", $signed(ri), $signed(rq));
            check("rand mag", 32'(m), 32'(isqrt(n)));
            check("rand lat", 32'(fc), 32'd17);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
